// File: rtl/sync_fifo_pkg.sv
// Shared constants and parameter validation for the flagged synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // True when the parameter set describes a buildable FIFO.
  function automatic bit fifo_params_ok(input int unsigned width,
                                        input int unsigned depth,
                                        input int unsigned fwft,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
    bit ok;
    ok = 1'b1;
    if (width < 1) ok = 1'b0;
    if (depth < 4) ok = 1'b0;
    if ((depth & (depth - 1)) != 0) ok = 1'b0;
    if (fwft > 1) ok = 1'b0;
    if (af_level < 1 || af_level > depth - 1) ok = 1'b0;
    if (ae_level > depth - 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bus of the flagged synchronous FIFO.
interface sync_fifo_flags_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned AW = $clog2(DEPTH);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] input_data;
  logic [WIDTH-1:0] output_data;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      fill_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, rd_en, input_data,
    input  output_data, empty, full, almost_empty, almost_full,
           fill_count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, input_data,
    output output_data, empty, full, almost_empty, almost_full,
           fill_count, overflow, underflow
  );

endinterface

// File: rtl/fifo_dp_ram.sv
// Storage array: synchronous write port, asynchronous read port, no reset.
module fifo_dp_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact fill count, threshold flags, error pulses and
// selectable standard / first-word-fall-through read path.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = FIFO_MODE_STD,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_flags_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (!fifo_params_ok(WIDTH, DEPTH, FWFT, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $error("sync_fifo_flags: illegal parameter set");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr, count_q;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             empty_q, full_q, almost_empty_q, almost_full_q;
  logic             overflow_q, underflow_q;
  logic             put_c, get_c;
  logic [WIDTH-1:0] rd_data;

  // Accept decisions use only the registered flags, so they never loop back.
  always_comb begin
    put_c      = bus.wr_en & ~full_q;
    get_c      = bus.rd_en & ~empty_q;
    wr_ptr_nxt = wr_ptr + PW'(put_c);
    rd_ptr_nxt = rd_ptr + PW'(get_c);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      count_q        <= count_nxt;
      empty_q        <= (count_nxt == '0);
      full_q         <= (count_nxt == PW'(DEPTH));
      almost_empty_q <= (count_nxt <= PW'(AE_LEVEL));
      almost_full_q  <= (count_nxt >= PW'(AF_LEVEL));
      overflow_q     <= bus.wr_en & full_q;
      underflow_q    <= bus.rd_en & empty_q;
    end
  end

  fifo_dp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (put_c),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.input_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  // Head word either falls through directly or is captured on each pop.
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign bus.output_data = rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (reset)      dout_q <= '0;
      else if (get_c) dout_q <= rd_data;
    end
    assign bus.output_data = dout_q;
  end

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.fill_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
